// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel multiplexer with manual select and a
// masked auto-scan mode. Each scanned channel is held for DWELL cycles.
// Optional build macro MUX_PARITY_EN adds a registered 'parity' output. It is
// the XOR of 'out' and is forced to 0 whenever 'out' is inactive.
//
// Handshake: there is no back-pressure. 'valid' qualifies 'out' and 'chan' on
// every cycle. When 'valid' is 0, 'out' is 0 and the consumer must ignore it.
// 'wrap' is a one-cycle pulse aligned with the first cycle of the new 'chan'.
module mux_scan_n #(
  parameter int   WIDTH    = 8,
  parameter int   CHANNELS = 4,
  parameter int   DWELL    = 4,
  localparam int  SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          chan,
  output logic                      valid,
  output logic                      wrap
`ifdef MUX_PARITY_EN
  ,
  output logic                      parity
`endif
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0] CH_LIM     = (SEL_W+1)'(CHANNELS);
  localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

  // Current FSM state; kept as a named register so checkers can bind to it.
  state_t           state;
  logic [7:0]       cnt;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic             s_ok;
  logic [SEL_W-1:0] low_idx;
  logic [SEL_W-1:0] above_idx;
  logic             above_found;
  logic [SEL_W-1:0] adv_idx;
  logic             adv_wrap;

  state_t           nxt_state;
  logic [WIDTH-1:0] nxt_out;
  logic [SEL_W-1:0] nxt_chan;
  logic             nxt_valid;
  logic             nxt_wrap;
  logic [7:0]       nxt_cnt;

  // Unpack the flattened input bus into per-channel words.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch_data[k] = in[k*WIDTH +: WIDTH];
    end
  end

  // The manual select is only legal below CHANNELS (non power-of-two counts).
  assign s_ok = ({1'b0, s} < CH_LIM);

  // Scan search: the lowest set mask bit, and the lowest set bit above chan.
  // Advancing picks 'above' when it exists; otherwise it wraps to the lowest.
  always_comb begin
    low_idx     = '0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (mask[k]) begin
        low_idx = SEL_W'(k);
        if (k > int'(chan)) begin
          above_idx   = SEL_W'(k);
          above_found = 1'b1;
        end
      end
    end
    adv_idx  = above_found ? above_idx : low_idx;
    adv_wrap = !above_found;
  end

  // Next-state and next-output decision. Priority is enable, then mode.
  always_comb begin
    nxt_state = state;
    nxt_out   = out;
    nxt_chan  = chan;
    nxt_valid = valid;
    nxt_wrap  = 1'b0;
    nxt_cnt   = cnt;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_out   = '0;
      nxt_valid = 1'b0;
      nxt_cnt   = '0;
    end else if (!mode) begin
      nxt_state = MANUAL;
      nxt_cnt   = '0;
      if (s_ok) begin
        nxt_out   = ch_data[s];
        nxt_chan  = s;
        nxt_valid = 1'b1;
      end else begin
        nxt_out   = '0;
        nxt_valid = 1'b0;
      end
    end else begin
      nxt_state = SCAN;
      if (mask == '0) begin
        // Nothing to scan: park with chan held until a bit is set again.
        nxt_out   = '0;
        nxt_valid = 1'b0;
        nxt_cnt   = '0;
      end else if (state != SCAN || !valid) begin
        // Entry or resume after an empty mask: start at the lowest channel.
        nxt_chan  = low_idx;
        nxt_out   = ch_data[low_idx];
        nxt_valid = 1'b1;
        nxt_cnt   = '0;
      end else if (!mask[chan] || cnt == DWELL_LAST) begin
        // Dwell expired, or the current channel was dropped from the mask.
        nxt_chan  = adv_idx;
        nxt_out   = ch_data[adv_idx];
        nxt_valid = 1'b1;
        nxt_wrap  = adv_wrap;
        nxt_cnt   = '0;
      end else begin
        // Hold the channel but keep tracking its live data.
        nxt_out   = ch_data[chan];
        nxt_valid = 1'b1;
        nxt_cnt   = cnt + 8'd1;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      chan  <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      out   <= nxt_out;
      chan  <= nxt_chan;
      valid <= nxt_valid;
      wrap  <= nxt_wrap;
      cnt   <= nxt_cnt;
    end
  end

`ifdef MUX_PARITY_EN
  // Parity of the word being registered; nxt_out is already 0 when inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ^nxt_out;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: bench for mux_scan_n (WIDTH=8, CHANNELS=4, DWELL=4).
// A reference model predicts the outputs after every clock edge and queues
// them. A monitor compares the DUT against each queued prediction, and
// directed checks confirm the documented example sequences.
module tb_mux_scan_n;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 4;
  localparam int SEL_W    = 2;
`ifdef MUX_PARITY_EN
  localparam int PW = WIDTH + SEL_W + 3;
`else
  localparam int PW = WIDTH + SEL_W + 2;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]          s;
  logic                      mode;
  logic                      enable;
  logic [CHANNELS-1:0]       mask;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          chan;
  logic                      valid;
  logic                      wrap;
`ifdef MUX_PARITY_EN
  logic                      parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q[$];

  mux_scan_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in_bus),
    .s      (s),
    .mode   (mode),
    .enable (enable),
    .mask   (mask),
    .out    (out),
    .chan   (chan),
    .valid  (valid),
    .wrap   (wrap)
`ifdef MUX_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: kind 0 = inactive, 1 = manual, 2 = scanning.
  // 'held' counts how many cycles the current scan channel has been shown.
  int               m_kind = 0;
  int               m_chan = 0;
  int               m_held = 0;
  logic [WIDTH-1:0] m_out  = '0;
  logic             m_valid = 1'b0;
  logic             m_wrap  = 1'b0;

  always @(posedge clk) begin
    m_wrap = 1'b0;
    if (rst) begin
      m_kind = 0; m_chan = 0; m_held = 0; m_out = '0; m_valid = 1'b0;
    end else if (!enable) begin
      m_kind = 0; m_held = 0; m_out = '0; m_valid = 1'b0;
    end else if (!mode) begin
      m_kind = 1; m_held = 0;
      if (int'(s) < CHANNELS) begin
        m_chan  = int'(s);
        m_valid = 1'b1;
        m_out   = in_bus[m_chan*WIDTH +: WIDTH];
      end else begin
        m_valid = 1'b0;
        m_out   = '0;
      end
    end else begin
      if (mask == '0) begin
        m_valid = 1'b0; m_out = '0; m_held = 0;
      end else if (m_kind != 2 || !m_valid) begin
        for (int k = CHANNELS - 1; k >= 0; k--) if (mask[k]) m_chan = k;
        m_held  = 1;
        m_valid = 1'b1;
      end else if (!mask[m_chan] || m_held == DWELL) begin
        int nxt;
        nxt = m_chan;
        for (int o = CHANNELS; o >= 1; o--) begin
          if (mask[(m_chan + o) % CHANNELS]) nxt = (m_chan + o) % CHANNELS;
        end
        m_wrap = (nxt <= m_chan);
        m_chan = nxt;
        m_held = 1;
      end else begin
        m_held++;
      end
      m_kind = 2;
      if (m_valid) m_out = in_bus[m_chan*WIDTH +: WIDTH];
    end
`ifdef MUX_PARITY_EN
    exp_q.push_back({m_out, SEL_W'(m_chan), m_valid, m_wrap, ^m_out});
`else
    exp_q.push_back({m_out, SEL_W'(m_chan), m_valid, m_wrap});
`endif
  end

  // Monitor: pop one prediction per edge and compare away from the edge.
  initial begin
    logic [PW-1:0] exp_v;
    logic [PW-1:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", 64'd1, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
`ifdef MUX_PARITY_EN
        got_v = {out, chan, valid, wrap, parity};
`else
        got_v = {out, chan, valid, wrap};
`endif
        check("outputs{out,chan,valid,wrap}", 64'(got_v), 64'(exp_v));
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus with directed checks
  initial begin
    logic [SEL_W-1:0] seq [13];
    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0};

    rst = 1'b1; in_bus = '0; s = '0; mode = 1'b0; enable = 1'b0; mask = '0;
    tick(); tick();
    check("reset_out", 64'(out), 64'd0);
    check("reset_chan", 64'(chan), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);

    // Manual select
    rst = 1'b0; in_bus = 32'hD4C3B2A1; enable = 1'b1; mode = 1'b0; s = 2'd2;
    tick();
    check("manual_s2_out", 64'(out), 64'hC3);
    check("manual_s2_chan", 64'(chan), 64'd2);
    check("manual_s2_valid", 64'(valid), 64'd1);
`ifdef MUX_PARITY_EN
    check("parity_c3", 64'(parity), 64'd0);
`endif
    s = 2'd0;
    tick();
    check("manual_s0_out", 64'(out), 64'hA1);
`ifdef MUX_PARITY_EN
    check("parity_a1", 64'(parity), 64'd1);
`endif

    // Enable gating
    s = 2'd2;
    tick();
    enable = 1'b0;
    tick();
    check("disable_out", 64'(out), 64'd0);
    check("disable_valid", 64'(valid), 64'd0);
    check("disable_chan", 64'(chan), 64'd2);
`ifdef MUX_PARITY_EN
    check("parity_invalid", 64'(parity), 64'd0);
`endif
    enable = 1'b1;
    tick();
    check("reenable_out", 64'(out), 64'hC3);

    // Scan sequence
    mode = 1'b1; mask = 4'b1011;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("scan_seq_chan", 64'(chan), 64'(seq[i]));
      check("scan_seq_wrap", 64'(wrap), (i == 12) ? 64'd1 : 64'd0);
    end

    // Mask edge cases
    repeat (5) tick();
    check("mid_dwell_chan1", 64'(chan), 64'd1);
    mask = 4'b1001;
    tick();
    check("mask_clear_adv", 64'(chan), 64'd3);
    mask = 4'b0000;
    tick();
    check("empty_mask_valid", 64'(valid), 64'd0);
    check("empty_mask_out", 64'(out), 64'd0);
    mask = 4'b0100;
    tick();
    check("single_chan", 64'(chan), 64'd2);
    check("single_valid", 64'(valid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("single_wrap", 64'(wrap), (i == 3 || i == 7) ? 64'd1 : 64'd0);
    end

    // Reset mid-scan
    mode = 1'b0; mask = 4'b1011;
    tick();
    mode = 1'b1;
    tick();
    repeat (8) tick();
    check("pre_reset_chan3", 64'(chan), 64'd3);
    rst = 1'b1;
    tick();
    check("midreset_out", 64'(out), 64'd0);
    check("midreset_chan", 64'(chan), 64'd0);
    check("midreset_valid", 64'(valid), 64'd0);
    check("midreset_wrap", 64'(wrap), 64'd0);
    rst = 1'b0; mask = 4'b1111;
    tick();
    check("post_reset_chan", 64'(chan), 64'd0);
    check("post_reset_valid", 64'(valid), 64'd1);
    repeat (3) tick();
    check("post_reset_hold", 64'(chan), 64'd0);
    tick();
    check("post_reset_adv", 64'(chan), 64'd1);

    // Randomized traffic checked by the model
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < CHANNELS; k++) in_bus[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      s = SEL_W'($urandom_range(0, CHANNELS - 1));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) mask = CHANNELS'($urandom);
      enable = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end

    rst = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
